// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side consumer stage for a dual-clock FIFO, clocked in the read domain.
// It pops the FIFO whenever data is available and the local skid buffer has
// credit. The buffer absorbs the FIFO's one-cycle read latency. Buffered words
// go out on a valid/ready stream. A counter tracks the words accepted
// downstream.
//
// Parameters
//   WIDTH      data word width (matches the FIFO data type)
//   BUF_DEPTH  skid buffer entries, 2..8 (>= 3 sustains 1 word/cycle)
//   CNT_W      width of the delivered-word counter
//
// Ports
//   rdclk      in   read-domain clock, all logic on the rising edge
//   rd_rst     in   asynchronous active-low reset
//   enable     in   gates new pops; buffered/in-flight words still drain
//   empty      in   FIFO empty flag, synchronous to rdclk
//   fifo_data  in   FIFO read data, valid the cycle after pop
//   pop        out  FIFO read strobe, one word per high cycle
//   m_data     out  stream data (buffer head entry)
//   m_valid    out  stream valid
//   m_ready    in   stream ready from downstream
//   rd_count   out  words accepted downstream since reset (wraps)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input  logic             rdclk,
    input  logic             rd_rst,
    input  logic             enable,
    input  logic             empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             pop,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
    // One extra bit so occ + inflight cannot wrap when occ == BUF_DEPTH.
    localparam int USED_W = OCC_W + 1;

    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0]  FULL_OCC   = OCC_W'(BUF_DEPTH);
    localparam logic [USED_W-1:0] DEPTH_USED = USED_W'(BUF_DEPTH);

    generate
        if (BUF_DEPTH < 2 || BUF_DEPTH > 8) begin : g_bad_depth
            $error("fifo_rd_stream: BUF_DEPTH must be in 2..8");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]  r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [OCC_W-1:0]  r_occ;
    logic              r_inflight;
    logic [CNT_W-1:0]  r_rd_count;

    logic [USED_W-1:0] w_used;
    logic              w_credit;
    logic              w_pop;
    logic              w_valid;
    logic              w_deq;
    logic [OCC_W-1:0]  w_occ_next;

    // Circular pointer advance, wrapping modulo BUF_DEPTH (not a power of 2
    // in general, so the wrap is explicit).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Pop / credit
    //
    // Credit counts both the words already buffered and the word that is
    // still in flight from last cycle's pop. Only registered state is used,
    // so m_ready has no combinational path to pop. A dequeue therefore frees
    // credit one cycle later.
    // -------------------------------------------------------------------------
    assign w_used   = USED_W'(r_occ) + USED_W'(r_inflight);
    assign w_credit = (w_used < DEPTH_USED);
    assign w_pop    = enable & ~empty & w_credit;

    // Gating with rd_rst keeps pop low for the whole reset interval, even
    // while enable and ~empty are already high.
    assign pop      = w_pop & rd_rst;

    // -------------------------------------------------------------------------
    // Stream side
    // -------------------------------------------------------------------------
    assign w_valid  = (r_occ != '0);
    assign w_deq    = w_valid & m_ready;

    assign m_valid  = w_valid;
    assign m_data   = r_buf[r_head];
    assign rd_count = r_rd_count;

    // Occupancy: a capture and a dequeue in the same cycle cancel out. A
    // captured word is never bypassed to the output, so it shows up as
    // m_valid one cycle after capture.
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_occ_next = r_occ;
        case ({r_inflight, w_deq})
            2'b10:   w_occ_next = r_occ + OCC_W'(1);
            2'b01:   w_occ_next = r_occ - OCC_W'(1);
            default: w_occ_next = r_occ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of every other register.
    always_ff @(posedge rdclk or negedge rd_rst) begin
        if (!rd_rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_rd_count <= '0;
        end else begin
            // The FIFO presents the popped word one cycle later.
            r_inflight <= w_pop;
            r_occ      <= w_occ_next;

            if (r_inflight) begin
                r_tail <= ptr_inc(r_tail);
            end

            if (w_deq) begin
                r_head     <= ptr_inc(r_head);
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Skid buffer storage
    // -------------------------------------------------------------------------
    // NOTE: this storage is reset on purpose. It is only a few flops, and
    // m_data reads the head entry directly, so clearing it is what makes
    // m_data read zero during and right after reset.
    always_ff @(posedge rdclk or negedge rd_rst) begin
        if (!rd_rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (r_inflight) begin
            r_buf[r_tail] <= fifo_data;
        end
    end

    // -------------------------------------------------------------------------
    // Safety properties
    // -------------------------------------------------------------------------
    // Credit invariant: buffered plus in-flight words never exceed the buffer.
    a_credit : assert property (
        @(posedge rdclk) disable iff (!rd_rst)
        w_used <= DEPTH_USED
    );

    // A capture into a full buffer without a matching dequeue is an overflow.
    a_no_overflow : assert property (
        @(posedge rdclk) disable iff (!rd_rst)
        !(r_inflight && !w_deq && (r_occ == FULL_OCC))
    );

    // The FIFO is never read while it reports empty.
    a_no_underflow : assert property (
        @(posedge rdclk) disable iff (!rd_rst)
        !(pop && empty)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Bench for fifo_rd_stream. The FIFO is modelled as a queue: a pop seen in one
// cycle presents the front word on fifo_data in the next cycle, and empty
// reflects the queue size. Every word loaded into the FIFO is pushed to an
// expected-order queue. A negedge monitor pops that queue on each stream
// handshake and also checks the counter, the credit bound, underflow, and
// output stability under backpressure. A second instance with CNT_W=4 shares
// all inputs and is used for the counter wrap.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int WIDTH     = 8;
    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = 16;

    logic             rdclk = 1'b0;
    logic             rd_rst;
    logic             enable;
    logic             empty;
    logic [WIDTH-1:0] fifo_data;
    logic             m_ready;

    logic             pop;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic [CNT_W-1:0] rd_count;

    logic             pop4;
    logic [WIDTH-1:0] m_data4;
    logic             m_valid4;
    logic [3:0]       rd_count4;

    always #5 rdclk = ~rdclk;

    fifo_rd_stream #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
        .rdclk     (rdclk),
        .rd_rst    (rd_rst),
        .enable    (enable),
        .empty     (empty),
        .fifo_data (fifo_data),
        .pop       (pop),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .rd_count  (rd_count)
    );

    fifo_rd_stream #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .CNT_W(4)) dut_w4 (
        .rdclk     (rdclk),
        .rd_rst    (rd_rst),
        .enable    (enable),
        .empty     (empty),
        .fifo_data (fifo_data),
        .pop       (pop4),
        .m_data    (m_data4),
        .m_valid   (m_valid4),
        .m_ready   (m_ready),
        .rd_count  (rd_count4)
    );

    int               vectors     = 0;
    int               miscompares = 0;
    logic [WIDTH-1:0] fq[$];        // FIFO contents
    logic [WIDTH-1:0] exp_q[$];     // words still owed downstream, in order
    int unsigned      delivered   = 0;
    int unsigned      popped      = 0;
    logic             last_pop    = 1'b0;
    logic             prev_stall  = 1'b0;
    logic [WIDTH-1:0] prev_data   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    // One read-clock cycle of the FIFO model: the word popped last cycle
    // appears on fifo_data, and empty follows the queue.
    task automatic tick();
        @(posedge rdclk);
        #1;
        if (last_pop && fq.size() != 0) fifo_data = fq.pop_front();
        empty = (fq.size() == 0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        enable  = 1'b1;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && n < 300) begin
            tick();
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        enable = 1'b0;
        tick();
    endtask

    // Monitor / scoreboard
    always @(negedge rdclk) begin
        last_pop = pop;
        if (!rd_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (pop) check("no_underflow", empty, 0);
            check("credit_bound", (popped - delivered + pop) <= BUF_DEPTH, 1);
            check("rd_count", rd_count, delivered[15:0]);
            check("rd_count_w4", rd_count4, delivered[3:0]);
            check("pop_w4", pop4, pop);
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_word: got 0x%0h, expected no word (t=%0t)", m_data, $time);
                end else begin
                    check("stream_data", m_data, exp_q.pop_front());
                end
                delivered++;
            end
            if (pop) popped++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_pop;
        int unsigned d0;

        rd_rst    = 1'b0;
        enable    = 1'b0;
        empty     = 1'b1;
        m_ready   = 1'b0;
        fifo_data = '0;

        // Reset then idle
        for (int c = 0; c < 3; c++) begin
            @(posedge rdclk);
            #3;
            check("rst_pop", pop, 0);
            check("rst_valid", m_valid, 0);
            check("rst_count", rd_count, 0);
            check("rst_data", m_data, 0);
        end
        #1 rd_rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            #2;
            check("idle_pop", pop, 0);
            check("idle_valid", m_valid, 0);
            check("idle_count", rd_count, 0);
        end

        // Streaming: 0x01..0x10 at full rate
        for (int w = 1; w <= 16; w++) load(8'(w));
        tick();
        enable  = 1'b1;
        m_ready = 1'b1;
        #2;
        check("stream_first_pop", pop, 1);
        for (int c = 1; c <= 18; c++) begin
            tick();
            #2;
            check("stream_valid", m_valid, (c >= 2 && c <= 17));
            if (c <= 15) check("stream_pop", pop, 1);
        end
        check("stream_count", rd_count, 16);
        enable = 1'b0;

        // Empty boundary: single word, plus counter wrap on the 4-bit copy
        load(8'hA5);
        tick();
        enable  = 1'b1;
        m_ready = 1'b1;
        #2;
        n_pop = 0;
        d0    = delivered;
        for (int c = 0; c < 6; c++) begin
            if (c != 0) begin
                tick();
                #2;
                check("edge_pop_low", pop, 0);
            end
            if (pop) n_pop++;
        end
        check("edge_pops", n_pop, 1);
        check("edge_words", delivered - d0, 1);
        check("edge_count", rd_count, 17);
        check("wrap_count_w4", rd_count4, 1);
        enable = 1'b0;

        // Backpressure from cycle 0
        for (int w = 1; w <= 16; w++) load(8'(w));
        tick();
        enable  = 1'b1;
        m_ready = 1'b0;
        #2;
        n_pop = 0;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) begin
                tick();
                #2;
            end
            if (pop) n_pop++;
            if (c >= 2) begin
                check("bp_valid", m_valid, 1);
                check("bp_head", m_data, 8'h01);
            end
        end
        check("bp_pops", n_pop, 3);
        check("bp_pop_low", pop, 0);
        drain("bp");

        // Enable dropped right after the pop of 0x05
        for (int w = 1; w <= 16; w++) load(8'(w));
        tick();
        enable  = 1'b1;
        m_ready = 1'b1;
        #2;
        for (int c = 1; c <= 4; c++) begin
            tick();
            #2;
        end
        check("drop_pop_w5", pop, 1);
        tick();
        enable = 1'b0;
        #2;
        check("drop_pop_same_cycle", pop, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            #2;
            check("drop_no_pop", pop, 0);
        end
        check("drop_fifo_left", fq.size(), 11);
        check("drop_fifo_head", fq[0], 8'h06);
        check("drop_owed", exp_q.size(), 11);
        drain("drop");

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            tick();
            if ($urandom_range(0, 2) == 0) load(8'($urandom));
            empty   = (fq.size() == 0);
            enable  = ($urandom_range(0, 9) < 8);
            m_ready = ($urandom_range(0, 9) < 7);
        end
        drain("rand");

        // Reset with two words buffered and one in flight
        m_ready = 1'b0;
        for (int w = 1; w <= 16; w++) load(8'(w));
        tick();
        enable = 1'b1;
        for (int c = 1; c <= 3; c++) tick();
        #2;
        check("mrst_valid_before", m_valid, 1);
        check("mrst_count_before", rd_count, delivered[15:0]);
        rd_rst = 1'b0;
        fq.delete();
        exp_q.delete();
        delivered = 0;
        popped    = 0;
        #1;
        check("mrst_valid", m_valid, 0);
        check("mrst_count", rd_count, 0);
        check("mrst_count_w4", rd_count4, 0);
        check("mrst_pop", pop, 0);
        check("mrst_data", m_data, 0);
        tick();
        tick();
        #1 rd_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #2;
            check("post_rst_valid", m_valid, 0);
            check("post_rst_pop", pop, 0);
        end
        enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
